// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32I main controller sequencing fetch, decode, execute, memory and writeback
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic               instr_done,
    output logic               halted,
    output logic [STATE_W-1:0] state
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    typedef struct packed {
        logic       adr;
        logic [1:0] rsrc;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
    } sel_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam sel_t SEL_FETCH = 10'b0_10_00_10_000;

    state_t st, nxt;
    sel_t   sel;
    logic   alu_f3_ok;

    // Datapath selects for the state being entered; the funct decode relies on the IR being stable after FETCH
    function automatic sel_t sel_of(input state_t s, input logic [2:0] f3, input logic f7);
        sel_t r;
        logic [2:0] fa;
        r  = '0;
        fa = f3 == 3'b000 ? ((s == EXECUTER && f7) ? 3'b001 : 3'b000) :
             f3 == 3'b010 ? 3'b101 :
             f3 == 3'b110 ? 3'b011 : 3'b010;
        case (s)
            FETCH:    r = SEL_FETCH;
            DECODE:   r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b01, b: 2'b01, alu: 3'b000};
            MEMADR:   r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b10, b: 2'b01, alu: 3'b000};
            MEMREAD:  r = '{adr: 1'b1, rsrc: 2'b00, a: 2'b00, b: 2'b00, alu: 3'b000};
            MEMWB:    r = '{adr: 1'b0, rsrc: 2'b01, a: 2'b00, b: 2'b00, alu: 3'b000};
            MEMWRITE: r = '{adr: 1'b1, rsrc: 2'b00, a: 2'b00, b: 2'b00, alu: 3'b000};
            EXECUTER: r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b10, b: 2'b00, alu: fa};
            EXECUTEI: r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b10, b: 2'b01, alu: fa};
            JAL:      r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b01, b: 2'b10, alu: 3'b000};
            BEQ:      r = '{adr: 1'b0, rsrc: 2'b00, a: 2'b10, b: 2'b00, alu: 3'b001};
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign alu_f3_ok = funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111;

    // Next-state sequencing; illegal encodings fall into TRAP at DECODE
    always_comb begin
        nxt = st;
        case (st)
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE:   nxt = (op == OP_LW || op == OP_SW) ? (funct3 == 3'b010 ? MEMADR : TRAP) :
                            op == OP_R   ? (alu_f3_ok ? EXECUTER : TRAP) :
                            op == OP_I   ? (alu_f3_ok ? EXECUTEI : TRAP) :
                            op == OP_BEQ ? (funct3 == 3'b000 ? BEQ : TRAP) :
                            op == OP_JAL ? JAL : TRAP;
            MEMADR:   nxt = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: nxt = ALUWB;
            EXECUTEI: nxt = ALUWB;
            JAL:      nxt = ALUWB;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
    end

    // State plus registered Moore selects, computed from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= FETCH;
            sel    <= SEL_FETCH;
            halted <= 1'b0;
        end else begin
            st     <= nxt;
            sel    <= sel_of(nxt, funct3, funct7b5);
            halted <= nxt == TRAP;
        end
    end

    assign adr_src     = sel.adr;
    assign result_src  = sel.rsrc;
    assign alu_src_a   = sel.a;
    assign alu_src_b   = sel.b;
    assign alu_control = sel.alu;
    assign imm_src     = op == OP_SW ? 2'b01 : op == OP_BEQ ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    assign pc_write    = !reset && ((st == FETCH && mem_ready) || st == JAL || (st == BEQ && zero));
    assign ir_write    = !reset && st == FETCH && mem_ready;
    assign mem_write   = !reset && st == MEMWRITE;
    assign reg_write   = !reset && (st == MEMWB || st == ALUWB);
    assign instr_done  = !reset && (st == MEMWB || st == ALUWB || st == BEQ || (st == MEMWRITE && mem_ready));
    assign state       = STATE_W'(st);
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized instruction-level check of mc_control_fsm against a per-class trace model
module tb_mc_control_fsm;
    logic       clk = 0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    int total = 0;
    int bad = 0;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_write(reg_write), .instr_done(instr_done),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] ev(input int s, input logic [6:0] o, input logic [2:0] f3,
                                       input logic f7, input logic mr, input logic z, input logic rs);
        logic pw, adr, mw, ir, rw, dn, h;
        logic [1:0] rsrc, a, b, imm;
        logic [2:0] alu, fa;
        {pw, adr, mw, ir, rw, dn, h} = '0;
        {rsrc, a, b, alu} = '0;
        imm = o == 7'h23 ? 2'b01 : o == 7'h63 ? 2'b10 : o == 7'h6f ? 2'b11 : 2'b00;
        fa = f3 == 0 ? ((s == 6 && f7) ? 3'd1 : 3'd0) : f3 == 2 ? 3'd5 : f3 == 6 ? 3'd3 : 3'd2;
        case (s)
            0:  begin b = 2; rsrc = 2; ir = mr; pw = mr; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  adr = 1;
            4:  begin rsrc = 1; rw = 1; dn = 1; end
            5:  begin adr = 1; mw = 1; dn = mr; end
            6:  begin a = 2; alu = fa; end
            7:  begin rw = 1; dn = 1; end
            8:  begin a = 2; b = 1; alu = fa; end
            9:  begin a = 1; b = 2; pw = 1; end
            10: begin a = 2; alu = 1; pw = z; dn = 1; end
            default: h = 1;
        endcase
        if (rs) {pw, mw, ir, rw, dn, h} = '0;
        return {pw, adr, mw, ir, rsrc, a, b, alu, imm, rw, dn, h};
    endfunction

    function automatic logic [17:0] dv();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                alu_control, imm_src, reg_write, instr_done, halted};
    endfunction

    task automatic hold_reset(input string tag);
        reset = 1;
        mem_ready = 1;
        #1;
        chk({tag, "_rst_state"}, 32'(state), 0);
        chk({tag, "_rst_out"}, 32'(dv()), 32'(ev(0, op, funct3, funct7b5, 1, zero, 1)));
        @(negedge clk);
        #2;
        chk({tag, "_rst_state2"}, 32'(state), 0);
        chk({tag, "_rst_out2"}, 32'(dv()), 32'(ev(0, op, funct3, funct7b5, 1, zero, 1)));
        mem_ready = 0;
        reset = 0;
    endtask

    // zm: 0/1 forces zero, 2 randomizes it; abort: trace index at which reset is asserted, -1 for none
    task automatic run(input logic [31:0] w, input int wf, input int wm, input int zm, input int abort);
        int sq[$];
        logic mq[$];
        logic legal_f3;
        op = w[6:0];
        funct3 = w[14:12];
        funct7b5 = w[30];
        legal_f3 = funct3 inside {3'd0, 3'd2, 3'd6, 3'd7};
        repeat (wf) begin sq.push_back(0); mq.push_back(0); end
        sq.push_back(0); mq.push_back(1);
        sq.push_back(1); mq.push_back(1'($urandom));
        if (op == 7'h03 && funct3 == 2) begin
            sq.push_back(2); mq.push_back(1'($urandom));
            repeat (wm) begin sq.push_back(3); mq.push_back(0); end
            sq.push_back(3); mq.push_back(1);
            sq.push_back(4); mq.push_back(1'($urandom));
        end else if (op == 7'h23 && funct3 == 2) begin
            sq.push_back(2); mq.push_back(1'($urandom));
            repeat (wm) begin sq.push_back(5); mq.push_back(0); end
            sq.push_back(5); mq.push_back(1);
        end else if (op == 7'h33 && legal_f3) begin
            sq.push_back(6); mq.push_back(1'($urandom));
            sq.push_back(7); mq.push_back(1'($urandom));
        end else if (op == 7'h13 && legal_f3) begin
            sq.push_back(8); mq.push_back(1'($urandom));
            sq.push_back(7); mq.push_back(1'($urandom));
        end else if (op == 7'h6f) begin
            sq.push_back(9); mq.push_back(1'($urandom));
            sq.push_back(7); mq.push_back(1'($urandom));
        end else if (op == 7'h63 && funct3 == 0) begin
            sq.push_back(10); mq.push_back(1'($urandom));
        end else begin
            repeat (3) begin sq.push_back(15); mq.push_back(1'($urandom)); end
            abort = sq.size() - 1;
        end
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            mem_ready = mq[i];
            zero = zm == 2 ? 1'($urandom) : 1'(zm);
            #2;
            chk($sformatf("state_%h_%0d", w, i), 32'(state), sq[i]);
            chk($sformatf("out_%h_%0d", w, i), 32'(dv()),
                32'(ev(sq[i], op, funct3, funct7b5, mem_ready, zero, 0)));
            if (i == abort) begin
                hold_reset($sformatf("abort_%h", w));
                return;
            end
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [6:0] ops [7];
        logic [2:0] f3s [4];
        int k;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h63, 7'h03};
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        k = $urandom_range(0, 7);
        w = 0;
        w[6:0] = k == 7 ? 7'($urandom) : ops[k];
        w[14:12] = $urandom_range(0, 4) == 0 ? 3'($urandom) :
                   (k <= 1 || k == 6) ? 3'd2 : k == 5 ? 3'd0 : f3s[$urandom_range(0, 3)];
        w[30] = 1'($urandom);
        return w;
    endfunction

    initial begin
        reset = 1;
        mem_ready = 1;
        zero = 0;
        op = 7'h33;
        funct3 = 0;
        funct7b5 = 0;
        repeat (2) @(negedge clk);
        #2;
        chk("init_state", 32'(state), 0);
        chk("init_out", 32'(dv()), 32'(ev(0, op, funct3, funct7b5, 1, zero, 1)));
        mem_ready = 0;
        reset = 0;
        run(32'h00412083, 0, 0, 2, -1);
        run(32'h00412083, 1, 3, 2, 5);
        run(32'h00112223, 0, 2, 2, -1);
        run(32'h002081B3, 0, 0, 2, -1);
        run(32'h402081B3, 0, 0, 2, -1);
        run(32'h40208193, 0, 0, 2, -1);
        run(32'h00208463, 0, 0, 1, -1);
        run(32'h00208463, 0, 0, 0, -1);
        run(32'h0000006F, 2, 0, 2, -1);
        run(32'h0000007F, 0, 0, 2, -1);
        run(32'h002091B3, 0, 0, 2, -1);
        for (int n = 0; n < 300; n++)
            run(rand_word(), $urandom_range(0, 2), $urandom_range(0, 3), 2,
                $urandom_range(0, 19) == 0 ? $urandom_range(0, 4) : -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
